// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared FSM encodings and width helper for the truth-table stimulus stage
// Purpose: state encoding used by truth_table_stim and a clog2 helper for counter sizing.
// Ports: none (package).
package stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bits needed to hold values 0 .. value-1, never less than one bit so a
  // single-cycle settle still gets a real counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with zero flag
// Purpose: times the settle window between driving a vector and sampling the DUT.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   load      in  1      load count with load_val (has priority over en)
//   load_val  in  WIDTH  value loaded on load
//   en        in  1      decrement by one; holds at zero
//   zero      out 1      count is zero
module settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_stim.sv
// rtl/truth_table_stim.sv - exhaustive truth-table stimulus and checker around a small combinational DUT
// Purpose: walks vectors 0 .. 2**N_IN-1, holds each on stim_o for a settle window, samples y_i
//          once per vector against EXPECT and reports error count, first failing vector and pass.
// Ports:
//   clk         in  1       rising-edge clock
//   rst         in  1       asynchronous active-high reset
//   start       in  1       begin a run (accepted in IDLE or DONE only)
//   abort       in  1       abandon a running sequence
//   y_i         in  1       DUT output
//   stim_o      out N_IN    DUT inputs (msb = a, lsb = b)
//   busy        out 1       run in progress
//   done        out 1       run completed, results valid
//   pass        out 1       run completed with no mismatches
//   err_count   out N_IN+1  mismatching vectors this run
//   fail_valid  out 1       at least one mismatch recorded
//   fail_vec    out N_IN    first mismatching vector
module truth_table_stim
  import stim_pkg::*;
#(
  parameter int                   N_IN          = 2,
  parameter int                   SETTLE_CYCLES = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECT        = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            y_i,
  output logic [N_IN-1:0] stim_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int              CNT_W       = clog2_min1(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic            timer_zero;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Counter reload happens in DRIVE; a reload on an aborted DRIVE is harmless
  // because every new run passes through DRIVE again before SETTLE.
  settle_timer #(
    .WIDTH (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_DRIVE),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .zero     (timer_zero)
  );

  always_comb begin
    mismatch = (y_i != EXPECT[vec]);
    err_next = err_count + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vec        <= '0;
      stim_o     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (busy && abort) begin
      // Abort beats everything while running; results so far are kept for inspection.
      state  <= ST_IDLE;
      stim_o <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          stim_o <= vec;
          state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
          if (vec == LAST_VEC) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec   <= vec + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          stim_o <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
